// File: rtl/fx_accum_pkg.sv
// Shared sizing and bound helpers for the fixed-point block accumulator.
// Constant functions only; evaluated at elaboration time.
package fx_accum_pkg;

  function automatic int fx_clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // Full-growth accumulator width: one extra integer bit per doubling of the block length.
  function automatic int fx_acc_w(input int in_w, input int acc_len);
    return in_w + fx_clog2(acc_len);
  endfunction

  function automatic longint fx_smax(input int w);
    return (longint'(1) << (w - 1)) - 1;
  endfunction

  function automatic longint fx_smin(input int w);
    return -(longint'(1) << (w - 1));
  endfunction

endpackage

// File: rtl/fx_accum_narrow.sv
// Combinational ACC_W->OUT_W conversion: sign-extend when widening; when narrowing,
// saturate if FX_ACCUM_SAT_EN is defined, otherwise drop MSBs (wrap-around).
module fx_accum_narrow
  import fx_accum_pkg::*;
#(
  parameter int ACC_W = 14,
  parameter int OUT_W = 14
) (
  input  logic signed [ACC_W-1:0] acc_i,
  output logic signed [OUT_W-1:0] out_o
);

  generate
    if (OUT_W >= ACC_W) begin : g_extend
      assign out_o = OUT_W'(acc_i);
    end else begin : g_narrow
`ifdef FX_ACCUM_SAT_EN
      localparam logic signed [ACC_W-1:0] MAX_V = ACC_W'(fx_smax(OUT_W));
      localparam logic signed [ACC_W-1:0] MIN_V = ACC_W'(fx_smin(OUT_W));

      always_comb begin
        out_o = OUT_W'(acc_i);
        if (acc_i > MAX_V)      out_o = OUT_W'(MAX_V);
        else if (acc_i < MIN_V) out_o = OUT_W'(MIN_V);
      end
`else
      assign out_o = OUT_W'(acc_i);
`endif
    end
  endgenerate

endmodule

// File: rtl/fx_block_accum.sv
// Sums ACC_LEN signed samples per block and emits one full-growth sum with a valid/ready
// output register. Output narrowing mode is selected by the FX_ACCUM_SAT_EN macro.
module fx_block_accum
  import fx_accum_pkg::*;
#(
  parameter int IN_W    = 13,
  parameter int ACC_LEN = 2,
  parameter int OUT_W   = 14
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic signed [IN_W-1:0]  i_data,
  input  logic                    i_valid,
  output logic                    o_ready,
  output logic signed [OUT_W-1:0] o_data,
  output logic                    o_valid,
  input  logic                    i_ready
);

  localparam int ACC_W = fx_acc_w(IN_W, ACC_LEN);
  localparam int CNT_W = (fx_clog2(ACC_LEN) < 1) ? 1 : fx_clog2(ACC_LEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACC_LEN - 1);

  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic signed [OUT_W-1:0] data_q, data_d;
  logic                    valid_q, valid_d;

  logic                    last_s;
  logic                    accept_s;
  logic signed [ACC_W-1:0] sum_s;
  logic signed [OUT_W-1:0] sum_nar_s;

  assign last_s   = (cnt_q == CNT_LAST);
  // Only the block-closing sample needs the output slot, so only it stalls.
  assign o_ready  = !(last_s && valid_q && !i_ready);
  assign accept_s = i_valid && o_ready;
  assign sum_s    = acc_q + ACC_W'(i_data);

  fx_accum_narrow #(
    .ACC_W (ACC_W),
    .OUT_W (OUT_W)
  ) u_narrow (
    .acc_i (sum_s),
    .out_o (sum_nar_s)
  );

  always_comb begin
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    valid_d = valid_q;
    if (valid_q && i_ready) valid_d = 1'b0;
    // A load on the consume edge overrides the clear, keeping o_valid high.
    if (accept_s) begin
      if (last_s) begin
        data_d  = sum_nar_s;
        valid_d = 1'b1;
        acc_d   = '0;
        cnt_d   = '0;
      end else begin
        acc_d = sum_s;
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      acc_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign o_data  = data_q;
  assign o_valid = valid_q;

endmodule

// File: tb/tb_fx_block_accum.sv
// Directed testbench for fx_block_accum: default 2-sample instance and a 4-sample
// instance with a 14-bit output that exercises narrowing.
module tb_fx_block_accum;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Instance A: defaults (IN_W=13, ACC_LEN=2, OUT_W=14)
  logic               rst_n_a, valid_a, ready_a, o_ready_a, o_valid_a;
  logic signed [12:0] data_a;
  logic signed [13:0] o_data_a;

  // Instance B: IN_W=13, ACC_LEN=4, OUT_W=14 (ACC_W=15, so narrowing applies)
  logic               rst_n_b, valid_b, ready_b, o_ready_b, o_valid_b;
  logic signed [12:0] data_b;
  logic signed [13:0] o_data_b;

  fx_block_accum u_dut_a (
    .i_clk   (clk),
    .i_rst_n (rst_n_a),
    .i_data  (data_a),
    .i_valid (valid_a),
    .o_ready (o_ready_a),
    .o_data  (o_data_a),
    .o_valid (o_valid_a),
    .i_ready (ready_a)
  );

  fx_block_accum #(
    .IN_W    (13),
    .ACC_LEN (4),
    .OUT_W   (14)
  ) u_dut_b (
    .i_clk   (clk),
    .i_rst_n (rst_n_b),
    .i_data  (data_b),
    .i_valid (valid_b),
    .o_ready (o_ready_b),
    .o_data  (o_data_b),
    .o_valid (o_valid_b),
    .i_ready (ready_b)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n_a = 1'b0; valid_a = 1'b1; data_a = 13'(100); ready_a = 1'b1;
    repeat (3) step();
    n_chk++; if (o_valid_a !== 1'b0) begin n_fail++; $display("FAIL reset_o_valid: got %0b expected 0", o_valid_a); end
    n_chk++; if (o_data_a !== 14'(0)) begin n_fail++; $display("FAIL reset_o_data: got %0d expected 0", o_data_a); end
    n_chk++; if (o_ready_a !== 1'b1) begin n_fail++; $display("FAIL reset_o_ready: got %0b expected 1", o_ready_a); end
    rst_n_a = 1'b1; valid_a = 1'b0;
    repeat (3) step();
    n_chk++; if (o_valid_a !== 1'b0) begin n_fail++; $display("FAIL reset_no_late_sum: got %0b expected 0", o_valid_a); end
    // Pending sum must be discarded by reset
    ready_a = 1'b0; valid_a = 1'b1; data_a = 13'(7);
    step();
    data_a = 13'(8);
    step();
    valid_a = 1'b0;
    n_chk++; if (o_data_a !== 14'(15)) begin n_fail++; $display("FAIL reset_pending_sum: got %0d expected 15", o_data_a); end
    rst_n_a = 1'b0;
    step();
    n_chk++; if (o_valid_a !== 1'b0) begin n_fail++; $display("FAIL reset_discard_valid: got %0b expected 0", o_valid_a); end
    n_chk++; if (o_data_a !== 14'(0)) begin n_fail++; $display("FAIL reset_discard_data: got %0d expected 0", o_data_a); end
    rst_n_a = 1'b1; ready_a = 1'b1;
    step();
  endtask

  task automatic test_defaults();
    ready_a = 1'b1; valid_a = 1'b1; data_a = 13'(4095);
    step();
    data_a = 13'(4095);
    step();
    valid_a = 1'b0;
    n_chk++; if (o_valid_a !== 1'b1) begin n_fail++; $display("FAIL max_sum_valid: got %0b expected 1", o_valid_a); end
    n_chk++; if (o_data_a !== 14'(8190)) begin n_fail++; $display("FAIL max_sum_data: got %0d expected 8190", o_data_a); end
    step();
    n_chk++; if (o_valid_a !== 1'b0) begin n_fail++; $display("FAIL max_sum_one_cycle: got %0b expected 0", o_valid_a); end
  endtask

  task automatic test_negative();
    valid_a = 1'b1; data_a = 13'(-4096);
    step();
    data_a = 13'(-4096);
    step();
    n_chk++; if (o_data_a !== 14'h2000) begin n_fail++; $display("FAIL min_sum_data: got %0d expected -8192", o_data_a); end
    data_a = 13'(-1);
    step();
    data_a = 13'(1);
    step();
    valid_a = 1'b0;
    n_chk++; if (o_valid_a !== 1'b1) begin n_fail++; $display("FAIL zero_sum_valid: got %0b expected 1", o_valid_a); end
    n_chk++; if (o_data_a !== 14'(0)) begin n_fail++; $display("FAIL zero_sum_data: got %0d expected 0", o_data_a); end
    step();
  endtask

  task automatic test_backpressure();
    ready_a = 1'b0; valid_a = 1'b1; data_a = 13'(1);
    step();
    data_a = 13'(2);
    step();
    n_chk++; if (o_data_a !== 14'(3)) begin n_fail++; $display("FAIL bp_first_sum: got %0d expected 3", o_data_a); end
    n_chk++; if (o_ready_a !== 1'b1) begin n_fail++; $display("FAIL bp_ready_first: got %0b expected 1", o_ready_a); end
    data_a = 13'(3);
    step();
    data_a = 13'(4);
    n_chk++; if (o_ready_a !== 1'b0) begin n_fail++; $display("FAIL bp_stall: got %0b expected 0", o_ready_a); end
    step();
    n_chk++; if (o_ready_a !== 1'b0) begin n_fail++; $display("FAIL bp_stall_hold: got %0b expected 0", o_ready_a); end
    n_chk++; if (o_data_a !== 14'(3)) begin n_fail++; $display("FAIL bp_data_hold: got %0d expected 3", o_data_a); end
    ready_a = 1'b1;
    #1;
    n_chk++; if (o_ready_a !== 1'b1) begin n_fail++; $display("FAIL bp_ready_release: got %0b expected 1", o_ready_a); end
    step();
    valid_a = 1'b0;
    n_chk++; if (o_valid_a !== 1'b1) begin n_fail++; $display("FAIL bp_b2b_valid: got %0b expected 1", o_valid_a); end
    n_chk++; if (o_data_a !== 14'(7)) begin n_fail++; $display("FAIL bp_b2b_data: got %0d expected 7", o_data_a); end
    step();
    n_chk++; if (o_valid_a !== 1'b0) begin n_fail++; $display("FAIL bp_drain: got %0b expected 0", o_valid_a); end
  endtask

  task automatic test_bubbles_midreset();
    rst_n_b = 1'b1; ready_b = 1'b1; valid_b = 1'b0;
    step();
    valid_b = 1'b1; data_b = 13'(10); step();
    valid_b = 1'b0; data_b = 13'(999); step();
    valid_b = 1'b1; data_b = 13'(20); step();
    valid_b = 1'b0; data_b = 13'(-999); step();
    n_chk++; if (o_valid_b !== 1'b0) begin n_fail++; $display("FAIL bubble_early: got %0b expected 0", o_valid_b); end
    valid_b = 1'b1; data_b = 13'(30); step();
    valid_b = 1'b0; step();
    valid_b = 1'b1; data_b = 13'(40); step();
    valid_b = 1'b0;
    n_chk++; if (o_valid_b !== 1'b1) begin n_fail++; $display("FAIL bubble_valid: got %0b expected 1", o_valid_b); end
    n_chk++; if (o_data_b !== 14'(100)) begin n_fail++; $display("FAIL bubble_sum: got %0d expected 100", o_data_b); end
    step();
    valid_b = 1'b1; data_b = 13'(5); step();
    data_b = 13'(6); step();
    valid_b = 1'b0; rst_n_b = 1'b0; step();
    rst_n_b = 1'b1;
    for (int i = 0; i < 4; i++) begin
      valid_b = 1'b1; data_b = 13'(1);
      step();
      if (i == 1) begin
        n_chk++; if (o_valid_b !== 1'b0) begin n_fail++; $display("FAIL midreset_no_partial: got %0b expected 0", o_valid_b); end
      end
    end
    valid_b = 1'b0;
    n_chk++; if (o_valid_b !== 1'b1) begin n_fail++; $display("FAIL midreset_valid: got %0b expected 1", o_valid_b); end
    n_chk++; if (o_data_b !== 14'(4)) begin n_fail++; $display("FAIL midreset_sum: got %0d expected 4", o_data_b); end
    step();
  endtask

  task automatic test_narrowing();
    logic signed [13:0] exp_pos, exp_neg;
`ifdef FX_ACCUM_SAT_EN
    exp_pos = 14'(8191);
    exp_neg = 14'(-8192);
`else
    exp_pos = 14'(-384);
    exp_neg = 14'(0);
`endif
    ready_b = 1'b1;
    for (int i = 0; i < 4; i++) begin
      valid_b = 1'b1; data_b = 13'(4000); step();
    end
    valid_b = 1'b0;
    n_chk++; if (o_data_b !== exp_pos) begin n_fail++; $display("FAIL narrow_pos: got %0d expected %0d", o_data_b, exp_pos); end
    step();
    for (int i = 0; i < 4; i++) begin
      valid_b = 1'b1; data_b = 13'(-4096); step();
    end
    valid_b = 1'b0;
    n_chk++; if (o_data_b !== exp_neg) begin n_fail++; $display("FAIL narrow_neg: got %0d expected %0d", o_data_b, exp_neg); end
    step();
  endtask

  initial begin
    rst_n_b = 1'b0; valid_b = 1'b0; ready_b = 1'b1; data_b = '0;
    test_reset();
    test_defaults();
    test_negative();
    test_backpressure();
    test_bubbles_midreset();
    test_narrowing();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before end of test");
    $fatal(1);
  end

endmodule
